// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM burst arbiter slice.
package sram_arb_pkg;

  localparam int SRAM_AW    = 11;
  localparam int SRAM_DW    = 32;
  localparam int SRAM_DEPTH = 2048;
  localparam int DEF_LW     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr, else lowest set request.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Two linear passes replace a modular rotate: upper half first, then wrap to index 0.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i] && (IW'(i) >= i_ptr)) begin
        o_any = 1'b1;
        o_idx = IW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[i]) begin
        o_any = 1'b1;
        o_idx = IW'(i);
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/sram_burst_arbiter.sv
// Round-robin burst sequencer sharing one single-port SRAM macro among NUM_REQ requesters.
module sram_burst_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = SRAM_AW,
  parameter int DW      = SRAM_DW,
  parameter int LW      = DEF_LW
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*LW-1:0]      req_len,
  input  logic [NUM_REQ*DW-1:0]      wr_data,
  output logic [NUM_REQ-1:0]         wr_ready,
  output logic                       rd_valid,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(NUM_REQ)-1:0] rd_id,
  output logic                       rd_last,
  output logic                       CEN,
  output logic                       WEN,
  output logic [AW-1:0]              A,
  output logic [DW-1:0]              D,
  input  logic [DW-1:0]              Q
);

  localparam int IW = $clog2(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_rr_ptr, r_owner, r_rd_id, w_idx;
  logic                r_we, r_rd_valid, r_rd_last;
  logic [AW-1:0]       r_addr, w_sel_addr;
  logic [LW-1:0]       r_len, r_beat, w_sel_len;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_any, w_sel_we, w_accept, w_last_beat;
  logic [DW-1:0]       w_own_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_accept    = (r_state == IDLE) && w_any;
  assign w_last_beat = (r_state == BURST) && (r_beat == r_len);

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_own_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IW'(i) == w_idx) begin
        w_sel_we   = req_we[i];
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_len  = req_len[i*LW +: LW];
      end
      if (IW'(i) == r_owner) w_own_wdata = wr_data[i*DW +: DW];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)       w_state_nxt = BURST;
      BURST:   if (w_last_beat) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset overrides the macro and handshake outputs combinationally so no access leaks out.
  always_comb begin
    CEN       = 1'b1;
    WEN       = 1'b1;
    A         = '0;
    D         = '0;
    req_ready = '0;
    wr_ready  = '0;
    if (RESETN) begin
      if (r_state == BURST) begin
        CEN = 1'b0;
        WEN = ~r_we;
        A   = r_addr;
        D   = w_own_wdata;
        wr_ready[r_owner] = r_we;
      end else begin
        req_ready = w_grant;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_id    <= '0;
    end else begin
      r_rd_valid <= (r_state == BURST) && !r_we;
      r_rd_last  <= w_last_beat && !r_we;
      if ((r_state == BURST) && !r_we) r_rd_id <= r_owner;
      if (w_accept) begin
        r_owner <= w_idx;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_len   <= w_sel_len;
        r_beat  <= '0;
      end else if (r_state == BURST) begin
        r_addr <= r_addr + AW'(1);
        r_beat <= r_beat + LW'(1);
        if (w_last_beat) r_rr_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign rd_id    = r_rd_id;
  assign rd_data  = Q;

endmodule

// File: tb/tb_sram_burst_arbiter.sv
// Randomised and directed bench for sram_burst_arbiter with a transaction-level model and SRAM macro.
module tb_sram_burst_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            CLK, RESETN;
  logic [N-1:0]    req_valid, req_ready, req_we, wr_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] wr_data;
  logic            rd_valid, rd_last;
  logic [DW-1:0]   rd_data;
  logic [1:0]      rd_id;
  logic            CEN, WEN;
  logic [AW-1:0]   A;
  logic [DW-1:0]   D, Q;

  sram_burst_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .LW(LW)) dut (
    .CLK(CLK), .RESETN(RESETN), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id),
    .rd_last(rd_last), .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // SRAM macro: active-low CEN/WEN, registered read data.
  logic [DW-1:0] mem [0:2047];
  bit mem_inited = 1'b0;
  always @(posedge CLK) begin
    if (!mem_inited) begin
      for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q <= mem[A];
    end
  end

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [LW-1:0] len; logic [DW-1:0] base;} desc_t;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data; logic [1:0] id; logic last;} acc_t;

  desc_t         rq [N][$];
  acc_t          exp_acc [$];
  logic [DW-1:0] ref_mem [0:2047];
  int            ptr;
  bit            exp_rd_v, exp_rd_last, prev_rst_low, rst_drive;
  logic [DW-1:0] exp_rd_d;
  logic [1:0]    exp_rd_id;
  int            cyc, n_checks, n_fail;
  int            g_log[$], gc_log[$], id_log[$], rdc_log[$];
  logic [AW-1:0] a_log[$];
  logic [DW-1:0] d_log[$];
  bit            l_log[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic desc_t mk(bit we, int addr, int len, logic [31:0] base);
    desc_t d;
    d.we = we; d.addr = AW'(addr); d.len = LW'(len); d.base = base;
    return d;
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit busy();
    bit b = (exp_acc.size() != 0) || exp_rd_v;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic clear_logs();
    g_log.delete(); gc_log.delete(); id_log.delete(); rdc_log.delete();
    a_log.delete(); d_log.delete(); l_log.delete();
  endtask

  task automatic compare();
    int    w;
    acc_t  a;
    desc_t d;
    if (!RESETN) begin
      chk("rst_CEN", CEN, 1); chk("rst_WEN", WEN, 1); chk("rst_A", A, 0); chk("rst_D", D, 0);
      chk("rst_req_ready", req_ready, 0); chk("rst_wr_ready", wr_ready, 0);
      if (prev_rst_low) begin
        chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_last", rd_last, 0); chk("rst_rd_id", rd_id, 0);
      end
      exp_acc.delete(); ptr = 0; exp_rd_v = 1'b0; prev_rst_low = 1'b1;
      return;
    end
    if (prev_rst_low) begin
      chk("post_rst_rd_valid", rd_valid, 0); chk("post_rst_rd_last", rd_last, 0); chk("post_rst_rd_id", rd_id, 0);
    end else begin
      chk("rd_valid", rd_valid, exp_rd_v);
      if (exp_rd_v) begin
        chk("rd_data", rd_data, exp_rd_d); chk("rd_id", rd_id, exp_rd_id); chk("rd_last", rd_last, exp_rd_last);
        d_log.push_back(rd_data); l_log.push_back(rd_last); id_log.push_back(int'(rd_id)); rdc_log.push_back(cyc);
      end
    end
    prev_rst_low = 1'b0;
    exp_rd_v = 1'b0;
    if (exp_acc.size() != 0) begin
      a = exp_acc.pop_front();
      chk("CEN", CEN, 0); chk("WEN", WEN, !a.we); chk("A", A, a.addr);
      chk("req_ready_busy", req_ready, 0);
      chk("wr_ready", wr_ready, a.we ? (4'b0001 << a.id) : 4'b0000);
      a_log.push_back(A);
      if (a.we) begin
        chk("D", D, a.data);
        ref_mem[a.addr] = a.data;
      end else begin
        exp_rd_v = 1'b1; exp_rd_d = ref_mem[a.addr]; exp_rd_id = a.id; exp_rd_last = a.last;
      end
    end else begin
      chk("CEN_idle", CEN, 1); chk("wr_ready_idle", wr_ready, 0);
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && rq[(ptr + k) % N].size() != 0) w = (ptr + k) % N;
      chk("req_ready", req_ready, (w < 0) ? 4'b0000 : (4'b0001 << w));
      if (w >= 0) begin
        d = rq[w].pop_front();
        g_log.push_back(onehot_idx(req_ready)); gc_log.push_back(cyc);
        for (int b = 0; b <= int'(d.len); b++) begin
          a.we = d.we; a.addr = AW'((int'(d.addr) + b) % 2048); a.data = d.base + 32'(b);
          a.id = 2'(w); a.last = (b == int'(d.len));
          exp_acc.push_back(a);
        end
        ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic step();
    logic [31:0] r;
    @(posedge CLK); #1;
    RESETN = rst_drive;
    for (int i = 0; i < N; i++) begin
      r = $urandom;
      if (rq[i].size() != 0) begin
        req_valid[i] = 1'b1; req_we[i] = rq[i][0].we;
        req_addr[i*AW +: AW] = rq[i][0].addr; req_len[i*LW +: LW] = rq[i][0].len;
      end else begin
        req_valid[i] = 1'b0; req_we[i] = r[0];
        req_addr[i*AW +: AW] = r[11:1]; req_len[i*LW +: LW] = r[15:12];
      end
      wr_data[i*DW +: DW] = $urandom;
      if (exp_acc.size() != 0 && exp_acc[0].we && exp_acc[0].id == 2'(i)) wr_data[i*DW +: DW] = exp_acc[0].data;
    end
    @(negedge CLK);
    compare();
    cyc++;
  endtask

  task automatic run_idle(int maxc);
    int c = 0;
    while (busy() && c < maxc) begin step(); c++; end
    chk("drain_timeout", busy(), 0);
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [AW-1:0] wrap_a [4];
  int            base_addr;

  initial begin
    RESETN = 1'b0; rst_drive = 1'b0; req_valid = '0; req_we = '0;
    req_addr = '0; req_len = '0; wr_data = '0;
    ptr = 0; exp_rd_v = 1'b0; prev_rst_low = 1'b0; cyc = 0; n_checks = 0; n_fail = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
    wrap_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    repeat (3) step();
    rst_drive = 1'b1;
    step();

    // Single write burst
    clear_logs();
    rq[1].push_back(mk(1, 'h010, 3, 32'hA0));
    run_idle(50);
    chk("w_grant_cnt", g_log.size(), 1);
    if (g_log.size() == 1) chk("w_grant_id", g_log[0], 1);
    chk("w_A_cnt", a_log.size(), 4);
    if (a_log.size() == 4) for (int k = 0; k < 4; k++) chk("w_A_lit", a_log[k], 11'h010 + 11'(k));

    // Read back
    clear_logs();
    rq[2].push_back(mk(0, 'h010, 3, 0));
    run_idle(50);
    chk("r_beats", d_log.size(), 4);
    if (d_log.size() == 4 && gc_log.size() == 1) begin
      for (int k = 0; k < 4; k++) begin
        chk("r_data_lit", d_log[k], 32'hA0 + 32'(k));
        chk("r_id_lit", id_log[k], 2);
        chk("r_last_lit", l_log[k], (k == 3));
      end
      chk("r_latency", rdc_log[0] - gc_log[0], 2);
    end

    // Address wrap, write then read
    clear_logs();
    rq[0].push_back(mk(1, 'h7FE, 3, 32'hB0));
    rq[0].push_back(mk(0, 'h7FE, 3, 0));
    run_idle(60);
    chk("wrap_A_cnt", a_log.size(), 8);
    if (a_log.size() == 8) for (int k = 0; k < 8; k++) chk("wrap_A_lit", a_log[k], wrap_a[k % 4]);
    chk("wrap_rd_cnt", d_log.size(), 4);
    if (d_log.size() == 4) for (int k = 0; k < 4; k++) chk("wrap_rd_lit", d_log[k], 32'hB0 + 32'(k));
    if (gc_log.size() == 2) chk("wrap_gap", gc_log[1] - gc_log[0], 5);

    // Fairness from reset with len-0 bursts
    rst_drive = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back(mk(r, 'h200 + i, 0, 32'h100 * i));
    step(); step();
    clear_logs();
    rst_drive = 1'b1;
    run_idle(100);
    chk("fair_cnt", g_log.size(), 8);
    if (g_log.size() == 8) for (int k = 0; k < 8; k++) begin
      chk("fair_order", g_log[k], k % 4);
      if (k > 0) chk("fair_gap", gc_log[k] - gc_log[k-1], 2);
    end

    // Contention during a 16-beat burst
    clear_logs();
    base_addr = $urandom_range(0, 2047);
    rq[0].push_back(mk(1, base_addr, 15, $urandom));
    step();
    repeat (5) step();
    rq[3].push_back(mk(0, base_addr, 2, 0));
    run_idle(100);
    chk("cont_cnt", g_log.size(), 2);
    if (g_log.size() == 2) begin
      chk("cont_first", g_log[0], 0); chk("cont_second", g_log[1], 3);
      chk("cont_wait", gc_log[1] - gc_log[0], 17);
    end

    // Reset at beat 5 of a read burst
    clear_logs();
    rq[2].push_back(mk(0, 'h100, 15, 0));
    step();
    rq[1].push_back(mk(0, 'h010, 1, 0));
    rq[3].push_back(mk(0, 'h011, 1, 0));
    repeat (5) step();
    rst_drive = 1'b0;
    step();
    rst_drive = 1'b1;
    run_idle(100);
    chk("rst_grant_cnt", g_log.size(), 3);
    if (g_log.size() == 3) begin
      chk("rst_g0", g_log[0], 2); chk("rst_g1", g_log[1], 1); chk("rst_g2", g_log[2], 3);
    end

    // Randomised traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 2 && $urandom_range(0, 7) == 0)
          rq[i].push_back(mk($urandom_range(0, 1), $urandom_range(0, 2047), $urandom_range(0, 15), $urandom));
      rst_drive = ($urandom_range(0, 249) != 0);
      step();
    end
    rst_drive = 1'b1;
    run_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_burst_arbiter.md
# sram_burst_arbiter

Round-robin burst arbiter and sequencer sharing one `sram_32b_w2048` macro (32-bit, 2048 words, active-low CEN/WEN, one-cycle registered-address read) among `NUM_REQ` requesters, e.g. activation fetch, weight fetch and psum writeback. It accepts one burst descriptor at a time and drives the macro for `len+1` consecutive beats with wrapping addresses. It returns read data tagged with requester id and last-beat flag. It sits between the systolic-array core/L0 buffers and the SRAM instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters.
- `AW`, default 11: SRAM address width (2048 words).
- `DW`, default 32: data width.
- `LW`, default 4: burst length field width; beats = `len`+1, so 1..16.

Ports (one clock; reset is synchronous and active-low):
- `CLK` input 1: clock. All state changes on the rising edge.
- `RESETN` input 1: synchronous, active-low reset.
- `req_valid` input `NUM_REQ`: burst request per requester.
- `req_ready` output `NUM_REQ`: one-hot acceptance strobe.
- `req_we` input `NUM_REQ`: 1 = write burst, 0 = read burst.
- `req_addr` input `NUM_REQ*AW`: packed start addresses. Requester i uses bits `[i*AW +: AW]`.
- `req_len` input `NUM_REQ*LW`: packed beat count minus one.
- `wr_data` input `NUM_REQ*DW`: packed write data per requester.
- `wr_ready` output `NUM_REQ`: beat-consumed strobe for the owner of a write burst.
- `rd_valid` output 1: read beat valid.
- `rd_data` output `DW`: read beat data.
- `rd_id` output `$clog2(NUM_REQ)`: owner of the read beat.
- `rd_last` output 1: final beat of the burst.
- `CEN` output 1: to macro, active-low chip enable.
- `WEN` output 1: to macro, low = write.
- `A` output `AW`: to macro, address.
- `D` output `DW`: to macro, write data.
- `Q` input `DW`: from macro, read data.

## Operation
- FSM states: IDLE, BURST.
  - IDLE: if any `req_valid`, pick a winner round-robin, searching upward from `rr_ptr`. In that cycle assert `req_ready[winner]` for 1 cycle. Latch owner, we, addr, len. Clear the beat counter. Go to BURST. With no request, stay in IDLE, `CEN`=1.
  - BURST: every cycle is one access.
    - `CEN`=0, `WEN`=~we, `A`=addr register, `D`=owner's `wr_data` slice.
    - Write burst: `wr_ready[owner]`=1 each beat. The requester must present valid data in every such cycle; there is no backpressure.
    - Per beat: addr ← (addr+1) mod 2048, so 2047 wraps to 0. The beat counter increments.
    - Beat == len: on the last beat, set `rr_ptr` ← owner+1 mod `NUM_REQ` and go to IDLE.
- `req_ready`, `wr_ready`, `CEN`, `WEN`, `A`, `D` are combinational from state registers only. They do not depend combinationally on `req_valid`, except `req_ready` in IDLE.
- Read return:
  - `rd_valid`, `rd_id` and `rd_last` are registered copies of the previous cycle's read-beat issue.
  - `rd_data`=`Q` passes through unregistered.
- The arbiter never preempts a burst. Requests arriving mid-burst wait; `req_valid` must be held until `req_ready`.
- Requesters are not reordered. Maximum wait is (`NUM_REQ`-1) bursts plus the IDLE gaps.

## Timing
- Reset:
  - While `RESETN`=0, the outputs are forced combinationally: `CEN`=1, `WEN`=1, `A`=0, `D`=0, `req_ready`=0, `wr_ready`=0.
  - At the reset edge: state=IDLE, `rr_ptr`=0, `rd_valid`=0, `rd_last`=0, `rd_id`=0.
  - Reset mid-burst abandons the burst with no further macro access. A read beat in flight is not reported.
- Acceptance cycle t (IDLE, `req_ready` high). Beats occupy cycles t+1 … t+1+len.
- Read beat issued in cycle k: `rd_valid`=1 with `Q` valid in cycle k+1. `rd_last` is set on the beat issued at len.
- Burst-to-burst gap: exactly 1 IDLE cycle. Sustained throughput is (len+1)/(len+2).
- Write to address X in cycle k, then read of X issued in cycle ≥k+1, returns the new data.
- Simultaneous requests: only the winner gets `req_ready`. The others stay pending.
- `rd_valid` may still be high in the first IDLE cycle after a read burst. This is legal and overlaps the next acceptance.

## Structure
- Package `sram_arb_pkg`:
  - state enum {IDLE, BURST}.
  - Constants `SRAM_AW`=11, `SRAM_DW`=32, `SRAM_DEPTH`=2048.
  - Default `LW`.
- Sub-module `rr_arbiter`:
  - Combinational round-robin priority picker.
  - Inputs: `NUM_REQ` request vector and pointer.
  - Outputs: one-hot grant and winner index.
  - The top level owns the pointer update.

## Test plan
- Single write burst: req 1, addr 0x010, len 3, data 0xA0..0xA3 → `req_ready[1]` one cycle. Four cycles with `CEN`=0, `WEN`=0, `A`=0x010..0x013, `wr_ready[1]`=1.
- Read back: req 2 reads 0x010, len 3 → `rd_valid` for 4 cycles, starting 2 cycles after acceptance. `rd_data`=0xA0..0xA3, `rd_id`=2, `rd_last` on 0xA3 only.
- Wrap: write addr 0x7FE, len 3 → `A` = 0x7FE, 0x7FF, 0x000, 0x001. Read-back matches.
- Fairness: all 4 requesters hold `req_valid` with len 0 from reset → grants in order 0, 1, 2, 3, 0, … One IDLE cycle between each.
- Contention mid-burst: req 0 is in a len-15 burst when req 3 asserts → no `req_ready[3]` until the cycle after beat 15. No change to `A` sequence.
- Reset mid-read-burst at beat 5 → `CEN`=1 in the reset cycle. `rd_valid`=0 after the edge. `rr_ptr`=0, and the next grant goes to the lowest pending index.
